// File: rtl/saturn_bus_ctrl.sv
// saturn_bus_ctrl: turns per-cycle core nibble requests into Saturn bus command
// sequences (LOAD_PC / PC_READ / PC_WRITE) and tracks a shadow bus pointer.
// Latency: hit = strobe on the send edge, read data on the next recv edge;
// a miss costs 6 bus cycles (LOAD_PC + 5 address nibbles) before the retry.
// Backpressure: o_stall holds the core during an address reload and forever
// after a bus error (which only reset clears).
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_en_bus_send/_recv       phase-0 / phase-1 one-clock enables
//   i_req, i_write, i_addr,   core access request (sampled on send phase)
//   i_wdata
//   o_nibble, o_valid         read data and one-clock update pulse
//   o_stall, o_error          core hold, sticky bus error
//   o_bus_strobe, o_bus_cmd,  registered bus command interface
//   o_bus_nibble_out
//   i_bus_nibble_in,          bus return nibble and error flag (recv phase)
//   i_bus_error
module saturn_bus_ctrl (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en_bus_send,
  input  logic        i_en_bus_recv,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [19:0] i_addr,
  input  logic [3:0]  i_wdata,
  output logic [3:0]  o_nibble,
  output logic        o_valid,
  output logic        o_stall,
  output logic        o_error,
  output logic        o_bus_strobe,
  output logic [3:0]  o_bus_cmd,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in,
  input  logic        i_bus_error
);

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_READ  = 4'd1;
  localparam logic [3:0] CMD_WRITE = 4'd2;
  localparam logic [3:0] CMD_LOAD  = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_CMD  = 3'd1,
    S_LOAD_ADDR = 3'd2,
    S_XFER      = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] bus_pc_q, bus_pc_d;
  logic        pc_known_q, pc_known_d;
  logic [19:0] ld_addr_q, ld_addr_d;
  logic [2:0]  ld_cnt_q, ld_cnt_d;
  logic        xfer_wr_q, xfer_wr_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        valid_q, valid_d;
  logic        stall_q, stall_d;
  logic        error_q, error_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [3:0]  nout_q, nout_d;

  logic [3:0]  ld_nibble;
  logic        hit;

  // Address nibble currently due on the bus, least significant first.
  always_comb begin
    ld_nibble = 4'd0;
    case (ld_cnt_q)
      3'd0:    ld_nibble = ld_addr_q[3:0];
      3'd1:    ld_nibble = ld_addr_q[7:4];
      3'd2:    ld_nibble = ld_addr_q[11:8];
      3'd3:    ld_nibble = ld_addr_q[15:12];
      3'd4:    ld_nibble = ld_addr_q[19:16];
      default: ld_nibble = 4'd0;
    endcase
  end

  assign hit = pc_known_q && (i_addr == bus_pc_q);

  always_comb begin
    state_d    = state_q;
    bus_pc_d   = bus_pc_q;
    pc_known_d = pc_known_q;
    ld_addr_d  = ld_addr_q;
    ld_cnt_d   = ld_cnt_q;
    xfer_wr_d  = xfer_wr_q;
    nibble_d   = nibble_q;
    valid_d    = 1'b0;
    stall_d    = stall_q;
    error_d    = error_q;
    strobe_d   = 1'b0;
    cmd_d      = cmd_q;
    nout_d     = nout_q;

    if (i_en_bus_recv) begin
      // Recv phase wins if both enables ever coincide.
      if (state_q != S_ERROR && i_bus_error) begin
        error_d    = 1'b1;
        stall_d    = 1'b1;
        pc_known_d = 1'b0;
        state_d    = S_ERROR;
      end else if (state_q == S_XFER) begin
        if (!xfer_wr_q) begin
          nibble_d = i_bus_nibble_in;
          valid_d  = 1'b1;
        end
        // The bus auto-increments its PC on every read/write; wraps at 2^20.
        bus_pc_d = bus_pc_q + 20'd1;
        state_d  = S_IDLE;
      end
    end else if (i_en_bus_send) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_req) begin
            strobe_d = 1'b1;
            if (hit) begin
              cmd_d     = i_write ? CMD_WRITE : CMD_READ;
              nout_d    = i_write ? i_wdata : 4'd0;
              xfer_wr_d = i_write;
              state_d   = S_XFER;
            end else begin
              ld_addr_d = i_addr;
              cmd_d     = CMD_LOAD;
              nout_d    = 4'd0;
              stall_d   = 1'b1;
              ld_cnt_d  = 3'd0;
              state_d   = S_LOAD_CMD;
            end
          end
        end
        S_LOAD_CMD: begin
          strobe_d = 1'b1;
          cmd_d    = CMD_LOAD;
          nout_d   = ld_nibble;
          ld_cnt_d = ld_cnt_q + 3'd1;
          state_d  = S_LOAD_ADDR;
        end
        S_LOAD_ADDR: begin
          strobe_d = 1'b1;
          cmd_d    = CMD_LOAD;
          nout_d   = ld_nibble;
          if (ld_cnt_q == 3'd4) begin
            // Fifth nibble out: the bus PC now matches the latched address.
            bus_pc_d   = ld_addr_q;
            pc_known_d = 1'b1;
            stall_d    = 1'b0;
            ld_cnt_d   = 3'd0;
            state_d    = S_IDLE;
          end else begin
            ld_cnt_d = ld_cnt_q + 3'd1;
          end
        end
        S_XFER:  ;
        S_ERROR: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      bus_pc_q   <= 20'd0;
      pc_known_q <= 1'b0;
      ld_addr_q  <= 20'd0;
      ld_cnt_q   <= 3'd0;
      xfer_wr_q  <= 1'b0;
      nibble_q   <= 4'd0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      error_q    <= 1'b0;
      strobe_q   <= 1'b0;
      cmd_q      <= CMD_NOP;
      nout_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      bus_pc_q   <= bus_pc_d;
      pc_known_q <= pc_known_d;
      ld_addr_q  <= ld_addr_d;
      ld_cnt_q   <= ld_cnt_d;
      xfer_wr_q  <= xfer_wr_d;
      nibble_q   <= nibble_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      error_q    <= error_d;
      strobe_q   <= strobe_d;
      cmd_q      <= cmd_d;
      nout_q     <= nout_d;
    end
  end

  assign o_nibble         = nibble_q;
  assign o_valid          = valid_q;
  assign o_stall          = stall_q;
  assign o_error          = error_q;
  assign o_bus_strobe     = strobe_q;
  assign o_bus_cmd        = cmd_q;
  assign o_bus_nibble_out = nout_q;

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// tb_saturn_bus_ctrl: directed bench for saturn_bus_ctrl.
// Each bus cycle is 4 clocks: send enable on clock 0, recv enable on clock 1.
// Expected values are hand-derived constants per test.
module tb_saturn_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_send = 1'b0;
  logic        en_recv = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [19:0] addr = 20'd0;
  logic [3:0]  wdata = 4'd0;
  logic [3:0]  o_nibble;
  logic        o_valid;
  logic        o_stall;
  logic        o_error;
  logic        o_bus_strobe;
  logic [3:0]  o_bus_cmd;
  logic [3:0]  o_bus_nibble_out;
  logic [3:0]  bus_in = 4'd0;
  logic        bus_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Samples taken by bus_cyc
  logic       s_strobe, s_strobe2, s_stall, s_valid, s_valid2, s_error;
  logic [3:0] s_cmd, s_nout, s_nib;

  always #5 clk = ~clk;

  saturn_bus_ctrl dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_en_bus_send    (en_send),
    .i_en_bus_recv    (en_recv),
    .i_req            (req),
    .i_write          (wr),
    .i_addr           (addr),
    .i_wdata          (wdata),
    .o_nibble         (o_nibble),
    .o_valid          (o_valid),
    .o_stall          (o_stall),
    .o_error          (o_error),
    .o_bus_strobe     (o_bus_strobe),
    .o_bus_cmd        (o_bus_cmd),
    .o_bus_nibble_out (o_bus_nibble_out),
    .i_bus_nibble_in  (bus_in),
    .i_bus_error      (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 4-clock bus cycle; samples at negedges, away from active edges.
  task automatic bus_cyc();
    @(negedge clk) en_send = 1'b1;
    @(negedge clk);
    en_send  = 1'b0;
    en_recv  = 1'b1;
    s_strobe = o_bus_strobe;
    s_cmd    = o_bus_cmd;
    s_nout   = o_bus_nibble_out;
    s_stall  = o_stall;
    @(negedge clk);
    en_recv   = 1'b0;
    s_valid   = o_valid;
    s_nib     = o_nibble;
    s_error   = o_error;
    s_strobe2 = o_bus_strobe;
    @(negedge clk);
    s_valid2  = o_valid;
  endtask

  // Full miss sequence: LOAD_PC command then 5 address nibbles, LSB first.
  task automatic load_seq(input string tag, input logic [19:0] a);
    logic [19:0] av;
    av = a;
    req = 1'b1;
    wr = 1'b0;
    addr = a;
    bus_cyc();
    chk({tag, "_ld_strobe"}, 32'(s_strobe), 32'd1);
    chk({tag, "_ld_cmd"},    32'(s_cmd),    32'd3);
    chk({tag, "_ld_nout"},   32'(s_nout),   32'd0);
    chk({tag, "_ld_stall"},  32'(s_stall),  32'd1);
    chk({tag, "_ld_pulse"},  32'(s_strobe2), 32'd0);
    for (int k = 0; k < 5; k++) begin
      bus_cyc();
      chk($sformatf("%s_an%0d_cmd", tag, k),   32'(s_cmd),   32'd3);
      chk($sformatf("%s_an%0d_nib", tag, k),   32'(s_nout),  32'(av[4*k +: 4]));
      chk($sformatf("%s_an%0d_stall", tag, k), 32'(s_stall), (k < 4) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic rd_hit(input string tag, input logic [19:0] a, input logic [3:0] d);
    req = 1'b1;
    wr = 1'b0;
    addr = a;
    bus_in = d;
    bus_cyc();
    chk({tag, "_strobe"}, 32'(s_strobe), 32'd1);
    chk({tag, "_cmd"},    32'(s_cmd),    32'd1);
    chk({tag, "_stall"},  32'(s_stall),  32'd0);
    chk({tag, "_valid"},  32'(s_valid),  32'd1);
    chk({tag, "_nib"},    32'(s_nib),    32'(d));
    chk({tag, "_vpulse"}, 32'(s_valid2), 32'd0);
  endtask

  task automatic wr_hit(input string tag, input logic [19:0] a, input logic [3:0] d);
    req = 1'b1;
    wr = 1'b1;
    addr = a;
    wdata = d;
    bus_cyc();
    chk({tag, "_strobe"}, 32'(s_strobe), 32'd1);
    chk({tag, "_cmd"},    32'(s_cmd),    32'd2);
    chk({tag, "_nout"},   32'(s_nout),   32'(d));
    chk({tag, "_valid"},  32'(s_valid),  32'd0);
    wr = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_stall"},  32'(o_stall),          32'd0);
    chk({tag, "_error"},  32'(o_error),          32'd0);
    chk({tag, "_strobe"}, 32'(o_bus_strobe),     32'd0);
    chk({tag, "_cmd"},    32'(o_bus_cmd),        32'd0);
    chk({tag, "_nout"},   32'(o_bus_nibble_out), 32'd0);
    chk({tag, "_valid"},  32'(o_valid),          32'd0);
    chk({tag, "_nibble"}, 32'(o_nibble),         32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_cleared("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read of 0x00000: full reload, then hit returning 0x2
    load_seq("cold", 20'h00000);
    rd_hit("cold_rd", 20'h00000, 4'h2);

    // Write 0xA at current bus_pc (0x00001), then 0x00002 must still hit
    wr_hit("wr", 20'h00001, 4'hA);
    rd_hit("wr_after", 20'h00002, 4'h7);

    // Idle cycle: no request, no strobe
    req = 1'b0;
    bus_cyc();
    chk("noreq_strobe", 32'(s_strobe), 32'd0);
    chk("noreq_valid",  32'(s_valid),  32'd0);

    // Sequential reads 0x00100..0x00103, then 0x00104 still a hit
    load_seq("seq", 20'h00100);
    for (int i = 0; i < 5; i++)
      rd_hit($sformatf("seq%0d", i), 20'h00100 + 20'(i), 4'(i + 3));

    // Jump to 0x12345: nibbles 5,4,3,2,1
    load_seq("jmp", 20'h12345);
    rd_hit("jmp_rd", 20'h12345, 4'hC);

    // Wrap: 0xFFFFF then 0x00000 without reload
    load_seq("wrap", 20'hFFFFF);
    rd_hit("wrap_hi", 20'hFFFFF, 4'h9);
    rd_hit("wrap_lo", 20'h00000, 4'h5);

    // Bus error during a hit read (0x00001)
    req = 1'b1;
    addr = 20'h00001;
    bus_in = 4'hF;
    bus_err = 1'b1;
    bus_cyc();
    bus_err = 1'b0;
    chk("err_strobe", 32'(s_strobe), 32'd1);
    chk("err_valid",  32'(s_valid),  32'd0);
    chk("err_flag",   32'(s_error),  32'd1);
    chk("err_stall",  32'(o_stall),  32'd1);
    for (int i = 0; i < 2; i++) begin
      bus_cyc();
      chk($sformatf("err_hold%0d_strobe", i), 32'(s_strobe), 32'd0);
      chk($sformatf("err_hold%0d_error", i),  32'(s_error),  32'd1);
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_cleared("err_rst");
    rst_n = 1'b1;
    // Previously-known address must reload after reset
    load_seq("post_err", 20'h00001);
    rd_hit("post_err_rd", 20'h00001, 4'h4);

    // Reset asserted mid-load
    req = 1'b1;
    addr = 20'h00ABC;
    bus_cyc();
    bus_cyc();
    bus_cyc();
    chk("mid_stall_pre", 32'(o_stall), 32'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_cleared("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    load_seq("mid_reload", 20'h00ABC);
    rd_hit("mid_rd", 20'h00ABC, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
